// File: rtl/instruction_fetch_if.sv
// Bundle between the fetch stage (master) and the instruction memory plus datapath (slave).
// Handshake: a fetch completes in any cycle where imem_req && imem_ready; the datapath
// consumes the presented instruction in any cycle where instr_valid && instr_ack.
interface instruction_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        instr_ack;
    logic        branch_taken;
    logic [15:0] branch_offset;
    logic        jump;
    logic [25:0] jump_target;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] fetch_count;
    logic [1:0]  fsm_state;

    modport master (
        output imem_req, imem_addr, instr, opcode, instr_valid, pc, fetch_count, fsm_state,
        input  imem_ready, imem_rdata, instr_ack, branch_taken, branch_offset, jump, jump_target
    );

    modport slave (
        input  imem_req, imem_addr, instr, opcode, instr_valid, pc, fetch_count, fsm_state,
        output imem_ready, imem_rdata, instr_ack, branch_taken, branch_offset, jump, jump_target
    );
endinterface

// File: rtl/instruction_fetch.sv
// Sequential fetch stage: holds the PC, fetches one word at a time from instruction
// memory and presents it to the control unit until the datapath acknowledges it.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst_n,
    instruction_fetch_if.master bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        launch_q, launch_d;
    logic        imem_req_q, imem_req_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        instr_valid_q, instr_valid_d;
    logic [31:0] fetch_count_q, fetch_count_d;

    logic [31:0] pc4;
    logic [31:0] branch_disp;
    logic [31:0] next_pc;

    always_comb begin
        pc4         = pc_q + 32'd4;
        branch_disp = {{14{bus.branch_offset[15]}}, bus.branch_offset, 2'b00};
        // Jump wins over a taken branch when both are flagged.
        if (bus.jump)
            next_pc = {pc4[31:28], bus.jump_target, 2'b00};
        else if (bus.branch_taken)
            next_pc = pc4 + branch_disp;
        else
            next_pc = pc4;
    end

    always_comb begin
        state_d       = state_q;
        launch_d      = launch_q;
        imem_req_d    = imem_req_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        fetch_count_d = fetch_count_q;
        case (state_q)
            IDLE: begin
                // The first edge after reset release is spent arming; the request
                // goes out on the second edge.
                if (launch_q) begin
                    state_d    = REQ;
                    imem_req_d = 1'b1;
                end else begin
                    launch_d = 1'b1;
                end
            end
            REQ: begin
                if (bus.imem_ready) begin
                    instr_d       = bus.imem_rdata;
                    instr_valid_d = 1'b1;
                    imem_req_d    = 1'b0;
                    state_d       = HOLD;
                end
            end
            HOLD: begin
                if (bus.instr_ack) begin
                    pc_d          = next_pc;
                    instr_valid_d = 1'b0;
                    fetch_count_d = fetch_count_q + 32'd1;
                    imem_req_d    = 1'b1;
                    state_d       = REQ;
                end
            end
            default: begin
                state_d    = IDLE;
                imem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            launch_q      <= 1'b0;
            imem_req_q    <= 1'b0;
            pc_q          <= RESET_PC;
            instr_q       <= 32'd0;
            instr_valid_q <= 1'b0;
            fetch_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            launch_q      <= launch_d;
            imem_req_q    <= imem_req_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign bus.imem_req    = imem_req_q;
    assign bus.imem_addr   = pc_q;
    assign bus.instr       = instr_q;
    assign bus.opcode      = instr_q[31:26];
    assign bus.instr_valid = instr_valid_q;
    assign bus.pc          = pc_q;
    assign bus.fetch_count = fetch_count_q;
    assign bus.fsm_state   = state_q;
endmodule
